// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//
// Serial program loader that sits in front of the single-cycle core. It receives a
// length-prefixed image over a UART line (8N1, LSB first), assembles little-endian 32-bit
// words, writes each one into the instruction memory, and keeps the core in reset until the
// whole image has arrived.
//
// Image format: N[7:0], N[15:8], then 4*N data bytes (word 0 byte 0 first). With the
// optional checksum, one extra byte follows: the XOR of all 4*N data bytes.
//
// Optional feature macro: BOOT_CHECKSUM_EN (adds the checksum state and XOR accumulator).
//
// Ports:
//   clk        in   system clock, single domain
//   rst        in   synchronous active-low reset
//   rx         in   UART receive line, idle high, asynchronous to clk
//   wr_en      out  one-cycle instruction memory write strobe
//   wr_addr    out  word address of the write (holds between strobes)
//   wr_data    out  word to write (holds between strobes)
//   cpu_rst_n  out  core reset, active-low; high only once the load succeeded
//   busy       out  load in progress
//   error      out  load failed; sticky until rst

module uart_boot_loader #(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [31:0]           wr_data,
   output logic                  cpu_rst_n,
   output logic                  busy,
   output logic                  error
);

   localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
   localparam int unsigned HALF_DIV = BAUD_DIV / 2;
   localparam int unsigned CNT_W    = $clog2(BAUD_DIV + 1);
   localparam int unsigned CAPACITY = 2 ** ADDR_WIDTH;

   // ------------------------------------------------------------------------------------
   // Input synchronizer
   // ------------------------------------------------------------------------------------
   logic rx_meta_q;
   logic rx_sync_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   // ------------------------------------------------------------------------------------
   // Receiver FSM
   // ------------------------------------------------------------------------------------
   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

   rx_state_e        rx_state_q;
   logic [CNT_W-1:0] baud_cnt_q;
   logic [2:0]       bit_cnt_q;
   logic [7:0]       rx_shift_q;
   logic             start_seen_q;  // a start bit survived its mid-bit check since reset

   logic baud_tick;
   logic half_tick;
   logic byte_valid;
   logic frame_err;

   assign baud_tick  = (baud_cnt_q == CNT_W'(BAUD_DIV - 1));
   assign half_tick  = (baud_cnt_q == CNT_W'(HALF_DIV - 1));
   // Both fire in the cycle of the mid-stop-bit sample.
   assign byte_valid = (rx_state_q == RxStop) && baud_tick && rx_sync_q;
   assign frame_err  = (rx_state_q == RxStop) && baud_tick && !rx_sync_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_state_q   <= RxIdle;
         baud_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         rx_shift_q   <= '0;
         start_seen_q <= 1'b0;
      end else begin
         unique case (rx_state_q)
            // The line idles high, so a low level seen here is a falling edge. Checking the
            // level rather than an edge also catches a start bit that began in the same
            // cycle as the previous stop-bit sample.
            RxIdle: begin
               baud_cnt_q <= '0;
               if (!rx_sync_q) begin
                  rx_state_q <= RxStart;
               end
            end
            RxStart: begin
               if (half_tick) begin
                  baud_cnt_q <= '0;
                  if (rx_sync_q) begin
                     rx_state_q <= RxIdle;  // glitch: line back high by mid start bit
                  end else begin
                     rx_state_q   <= RxData;
                     bit_cnt_q    <= '0;
                     start_seen_q <= 1'b1;
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q + 1'b1;
               end
            end
            RxData: begin
               if (baud_tick) begin
                  baud_cnt_q <= '0;
                  rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                  bit_cnt_q  <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 3'd7) begin
                     rx_state_q <= RxStop;
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q + 1'b1;
               end
            end
            RxStop: begin
               if (baud_tick) begin
                  baud_cnt_q <= '0;
                  rx_state_q <= RxIdle;
               end else begin
                  baud_cnt_q <= baud_cnt_q + 1'b1;
               end
            end
            default: rx_state_q <= RxIdle;
         endcase
      end
   end

   // ------------------------------------------------------------------------------------
   // Load FSM
   // ------------------------------------------------------------------------------------
   typedef enum logic [2:0] {
      LdLenLo,
      LdLenHi,
      LdData,
`ifdef BOOT_CHECKSUM_EN
      LdChk,
`endif
      LdDone,
      LdErr
   } ld_state_e;

   ld_state_e             ld_state_q;
   logic [15:0]           len_q;
   logic [ADDR_WIDTH:0]   idx_q;       // one extra bit so N = capacity does not wrap
   logic [1:0]            byte_sel_q;
   logic [23:0]           word_q;      // first three bytes of the word being assembled
   logic                  wr_en_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [31:0]           wr_data_q;
   logic                  cpu_rst_n_q;
   logic                  busy_q;
   logic                  error_q;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]            csum_q;
`endif

   logic        ld_terminal;
   logic [15:0] len_new;

   assign ld_terminal = (ld_state_q == LdDone) || (ld_state_q == LdErr);
   assign len_new     = {rx_shift_q, len_q[7:0]};

   always_ff @(posedge clk) begin
      if (!rst) begin
         ld_state_q  <= LdLenLo;
         len_q       <= '0;
         idx_q       <= '0;
         byte_sel_q  <= '0;
         word_q      <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         cpu_rst_n_q <= 1'b0;
         busy_q      <= 1'b0;
         error_q     <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         wr_en_q     <= 1'b0;
         // Status outputs follow the state one cycle later, so cpu_rst_n rises the cycle
         // after the final strobe (or the checksum byte).
         cpu_rst_n_q <= (ld_state_q == LdDone);
         error_q     <= (ld_state_q == LdErr);
         busy_q      <= start_seen_q && !ld_terminal;

         if (frame_err && !ld_terminal) begin
            ld_state_q <= LdErr;
         end else if (byte_valid) begin
            unique case (ld_state_q)
               LdLenLo: begin
                  len_q[7:0] <= rx_shift_q;
                  ld_state_q <= LdLenHi;
               end
               LdLenHi: begin
                  len_q[15:8] <= rx_shift_q;
                  if (len_new == 16'd0 || 32'(len_new) > CAPACITY) begin
                     ld_state_q <= LdErr;
                  end else begin
                     ld_state_q <= LdData;
                  end
               end
               LdData: begin
                  byte_sel_q <= byte_sel_q + 1'b1;
`ifdef BOOT_CHECKSUM_EN
                  csum_q     <= csum_q ^ rx_shift_q;
`endif
                  if (byte_sel_q == 2'd3) begin
                     wr_en_q   <= 1'b1;
                     wr_addr_q <= idx_q[ADDR_WIDTH-1:0];
                     wr_data_q <= {rx_shift_q, word_q};
                     idx_q     <= idx_q + 1'b1;
                     if (32'(idx_q) + 32'd1 == 32'(len_q)) begin
`ifdef BOOT_CHECKSUM_EN
                        ld_state_q <= LdChk;
`else
                        ld_state_q <= LdDone;
`endif
                     end
                  end else begin
                     word_q <= {rx_shift_q, word_q[23:8]};
                  end
               end
`ifdef BOOT_CHECKSUM_EN
               LdChk: begin
                  ld_state_q <= (rx_shift_q == csum_q) ? LdDone : LdErr;
               end
`endif
               default: ;  // DONE and ERR ignore further traffic
            endcase
         end
      end
   end

   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign cpu_rst_n = cpu_rst_n_q;
   assign busy      = busy_q;
   assign error     = error_q;

endmodule
